// File: rtl/core_insn_loader_pkg.sv
// Shared sizing, state encoding and helpers for the per-core instruction loader.
// Build with LOADER_PROTO_CHECK_EN defined to enable part-index sequencing checks.
package core_insn_loader_pkg;

   localparam int INSN_LOAD_TIME = 4;
   localparam int INSN_BUS_W = 32;
   localparam int INSN_W = 16;
   localparam int REG_W = 8;

   localparam int CNT_W =
      ($clog2(INSN_LOAD_TIME) > 1) ? $clog2(INSN_LOAD_TIME) : 1;
   localparam int FRAME_W = INSN_LOAD_TIME * INSN_BUS_W;
   localparam int IPF = FRAME_W / INSN_W;
   localparam int IDX_W = ($clog2(IPF) > 1) ? $clog2(IPF) : 1;

   localparam logic [CNT_W-1:0] LAST_PART = CNT_W'(INSN_LOAD_TIME - 1);
   localparam logic [IDX_W-1:0] LAST_INSN = IDX_W'(IPF - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      ISSUE = 2'd2,
      DRAIN = 2'd3
   } state_t;

   function automatic logic cnt_in_range(input logic [CNT_W-1:0] c);
      return int'(c) < INSN_LOAD_TIME;
   endfunction

endpackage

// File: rtl/core_insn_loader_if.sv
// Issue handshake between the loader (master) and the core pipeline (slave).
interface core_insn_loader_if;
   import core_insn_loader_pkg::*;

   logic [INSN_W-1:0] insn_out;
   logic insn_valid;
   logic insn_accept;
   logic core_busy;

   modport master (
      output insn_out,
      output insn_valid,
      input  insn_accept,
      input  core_busy
   );

   modport slave (
      input  insn_out,
      input  insn_valid,
      output insn_accept,
      output core_busy
   );

endinterface

// File: rtl/core_insn_frame_buf.sv
// Frame part register file with the per-instruction read mux.
module core_insn_frame_buf
   import core_insn_loader_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic wr_en,
   input  logic [CNT_W-1:0] wr_idx,
   input  logic [INSN_BUS_W-1:0] wr_data,
   input  logic [IDX_W-1:0] rd_idx,
   output logic [INSN_W-1:0] rd_insn
);

   logic [INSN_LOAD_TIME-1:0][INSN_BUS_W-1:0] parts;
   logic [FRAME_W-1:0] frame;

   assign frame = parts;
   assign rd_insn = frame[rd_idx*INSN_W +: INSN_W];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parts <= '0;
      end else if (wr_en && cnt_in_range(wr_idx)) begin
         parts[wr_idx] <= wr_data;
      end
   end

endmodule

// File: rtl/core_insn_loader.sv
// Per-core instruction loader: collects a frame, preloads R0, issues, drains.
// LOADER_PROTO_CHECK_EN enables expected-part tracking and protocol_err.
module core_insn_loader
   import core_insn_loader_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic [CNT_W-1:0] insn_load_counter,
   input  logic [INSN_BUS_W-1:0] insn_data,
   input  logic init_r0_vect,
   input  logic [REG_W-1:0] init_r0,
   output logic ready,
   output logic r0_wr,
   output logic [REG_W-1:0] r0_value,
   output logic protocol_err,
   core_insn_loader_if.master io
);

   state_t state;
   logic [IDX_W-1:0] idx;
   logic valid_q;
   logic r0_pend;
   logic take;
   logic wr_en;
   logic cap;
   logic commit;
   logic bad;

   assign take = start & ready;
   assign io.insn_valid = valid_q;

`ifdef LOADER_PROTO_CHECK_EN
   logic [CNT_W-1:0] exp_cnt;

   always_comb begin
      wr_en = 1'b0;
      bad = 1'b0;
      if (take) begin
         if (!cnt_in_range(insn_load_counter)) begin
            bad = 1'b1;
         end else if (insn_load_counter != exp_cnt) begin
            bad = 1'b1;
            // an out-of-order part 0 restarts the frame
            wr_en = (insn_load_counter == '0);
         end else begin
            wr_en = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exp_cnt <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (commit) exp_cnt <= '0;
         else if (wr_en) exp_cnt <= insn_load_counter + 1'b1;
         if (bad) protocol_err <= 1'b1;
      end
   end
`else
   assign wr_en = take;
   assign bad = 1'b0;
   assign protocol_err = 1'b0;
`endif

   assign cap = wr_en && (insn_load_counter == '0);
   assign commit = wr_en && !bad && (insn_load_counter == LAST_PART);

   core_insn_frame_buf u_buf (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en),
      .wr_idx  (insn_load_counter),
      .wr_data (insn_data),
      .rd_idx  (idx),
      .rd_insn (io.insn_out)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
         ready <= 1'b1;
         valid_q <= 1'b0;
         idx <= '0;
         r0_pend <= 1'b0;
         r0_value <= '0;
         r0_wr <= 1'b0;
      end else begin
         r0_wr <= 1'b0;
         unique case (state)
            IDLE, LOAD: begin
               if (cap) begin
                  r0_pend <= init_r0_vect;
                  r0_value <= init_r0;
               end
               if (commit) begin
                  state <= ISSUE;
                  ready <= 1'b0;
                  valid_q <= 1'b1;
                  idx <= '0;
                  r0_wr <= r0_pend;
               end else if (wr_en) begin
                  state <= LOAD;
               end
            end
            ISSUE: begin
               if (io.insn_accept) begin
                  if (idx == LAST_INSN) begin
                     idx <= '0;
                     valid_q <= 1'b0;
                     state <= DRAIN;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            DRAIN: begin
               if (!io.core_busy) begin
                  state <= IDLE;
                  ready <= 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/core_insn_loader.md
Name: core_insn_loader

Overview:
Per-core receiver for the task scheduler's instruction-load interface; one instance sits at the front of each core.
- Collects the INSN_LOAD_TIME parts of one instruction frame, presented on insn_data and indexed by insn_load_counter while this core's start bit is high.
- Forwards an optional R0 preload to the core.
- Issues the frame's instructions one at a time to the core pipeline over a valid/accept handshake.
- Holds ready low from frame commit until the core has drained, which is what gates the scheduler's next start and its fences.

Parameters:
- INSN_LOAD_TIME, 4, parts per frame (≥2).
- INSN_BUS_W, 32, bits per part.
- INSN_W, 16, instruction width; INSN_BUS_W must be a multiple of INSN_W.
- REG_W, 8, R0 width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  this core's bit of the scheduler Start vector.
- insn_load_counter  in  CNT_W=max(1,clog2(INSN_LOAD_TIME))  part index.
- insn_data  in  INSN_BUS_W  frame part.
- init_r0_vect  in  1  this core's bit of Init_R0_Vect.
- init_r0  in  REG_W  this core's slice of Init_R0.
- ready  out  1  to the scheduler Ready vector.
- insn_out  out  INSN_W  instruction to the pipeline.
- insn_valid  out  1  insn_out is valid.
- insn_accept  in  1  pipeline takes insn_out.
- core_busy  in  1  pipeline still holds in-flight instructions.
- r0_wr  out  1  one-cycle R0 write strobe.
- r0_value  out  REG_W  value to write into R0.
- protocol_err  out  1  sticky sequencing error.

Behaviour:
- Derived constants:
  - FRAME_W = INSN_LOAD_TIME*INSN_BUS_W.
  - IPF = FRAME_W/INSN_W (instructions per frame).
  - IDX_W = clog2(IPF).
- Frame layout:
  - Part k occupies frame bits [k*INSN_BUS_W +: INSN_BUS_W].
  - Instruction j occupies frame bits [j*INSN_W +: INSN_W].
  - Instructions issue in ascending j.
- Reset values: ready=1, insn_valid=0, insn_out=0, r0_wr=0, r0_value=0, protocol_err=0, state=IDLE, issue index=0. Reset is asynchronous and takes effect mid-operation in any state; a partial frame is discarded.
- A part is taken only in a cycle with start=1 and ready=1.
- IDLE (ready=1):
  - A part with counter==0 is written to part 0.
  - init_r0_vect and init_r0 are captured into r0_pend and r0_value.
  - Next state is LOAD.
- LOAD (ready=1):
  - Each part is written at index insn_load_counter.
  - start=0 cycles are gaps: the loader holds state.
  - A part with counter==INSN_LOAD_TIME-1 commits the frame and moves to ISSUE.
- Commit latency: last part taken in cycle t gives, at cycle t+1, ready=0, insn_valid=1 with instruction 0, and r0_wr=1 for exactly one cycle if r0_pend=1.
- R0 preload accompanies every frame whose part 0 saw init_r0_vect=1. R0 is a preload/ID register by program convention.
- ISSUE (ready=0):
  - insn_out/insn_valid stay stable until insn_accept.
  - On valid&accept the index increments.
  - Accept of index IPF-1 moves to DRAIN; insn_valid=0 the next cycle.
- DRAIN (ready=0): when core_busy=0, move to IDLE; ready=1 the next cycle.
- start seen while ready=0 is ignored; parts are never dropped silently in IDLE/LOAD.
- Degenerate case INSN_LOAD_TIME==1 is not supported.

Optional Feature:
- Macro: LOADER_PROTO_CHECK_EN.
- Defined:
  - An expected-part counter is tracked.
  - An accepted part whose index differs from expected sets protocol_err (sticky until reset).
  - If the mismatched index is 0, the frame restarts from part 0 (recaptures R0); any other mismatched part is dropped.
  - A counter ≥ INSN_LOAD_TIME always sets protocol_err and the part is dropped.
- Undefined:
  - The counter is the direct write index; no check.
  - Commit on counter==INSN_LOAD_TIME-1.
  - protocol_err is tied 0.

Decomposition:
- The shared include (SharedInc) holds: INSN_LOAD_TIME, INSN_BUS_W, INSN_W, REG_W, the CNT/IDX range macros, part/instruction slice-range macros, and the state encoding (IDLE=0, LOAD=1, ISSUE=2, DRAIN=3).
- One sub-module, core_insn_frame_buf: the part-write register file plus the instruction-select mux.
- Control FSM, R0 capture and protocol check stay in core_insn_loader.

Test Plan:
- Reset: hold reset=0, then release → ready=1, insn_valid=0, r0_wr=0, protocol_err=0; no state change without start.
- Basic frame (4×32, INSN_W=16):
  - Stimulus: parts 0x00020001, 0x00040003, 0x00060005, 0x00080007 on consecutive cycles; accept=1.
  - Response: insn_out 0x0001..0x0008 on 8 consecutive cycles from t+1.
  - ready=0 from t+1 until the cycle after core_busy falls.
- Backpressure: accept pattern 1,0,0,1 during ISSUE → insn_out/insn_valid stable through the stall; no instruction skipped or repeated.
- R0:
  - Part 0 with init_r0_vect=1, init_r0=0x5A → single r0_wr pulse, r0_value=0x5A, at t+1.
  - Next frame with vect=0 → no pulse.
- Gaps, reset, late start:
  - start low for 3 cycles between parts 1 and 2 → correct frame.
  - reset asserted mid-ISSUE → immediate return to reset values.
  - start while ready=0 → ignored.
- LOADER_PROTO_CHECK_EN:
  - Counter sequence 0,1,3 → protocol_err=1, part 3 dropped, frame not committed.
  - Then 0,1,2,3 → frame commits; protocol_err stays 1.
